// File: rtl/serial_peri_pkg.sv
// Shared definitions for the serial peripheral link: receiver state encoding and
// default word/buffer sizes, also used by the transmitter-side peripheral.
package serial_peri_pkg;

   localparam int DEFAULT_WIDTH      = 16;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RECV = 2'd2
   } rx_state_e;

endpackage

// File: rtl/serial_sync_fifo.sv
// Synchronous word FIFO with a registered head word; simultaneous push and pop
// are both honoured, including a pop that frees room for a push while full.
module serial_sync_fifo #(
   parameter int WIDTH      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic [WIDTH-1:0]              head
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] head_r;

   logic             pop_ok_s;
   logic             push_ok_s;
   logic [CNT_W-1:0] count_next_s;
   logic [PTR_W-1:0] rd_next_s;
   logic [WIDTH-1:0] head_next_s;

   assign full  = (count_r == CNT_W'(FIFO_DEPTH));
   assign empty = (count_r == {CNT_W{1'b0}});
   assign count = count_r;
   assign head  = head_r;

   // Accept/advance decisions and next head word.
   always_comb begin
      pop_ok_s     = pop & ~empty;
      push_ok_s    = push & (~full | pop_ok_s);
      count_next_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
      rd_next_s    = pop_ok_s ? (rd_ptr_r + PTR_W'(1'b1)) : rd_ptr_r;
      head_next_s  = head_r;
      if (count_next_s == {CNT_W{1'b0}}) begin
         head_next_s = head_r;
      end else if (count_r == CNT_W'(pop_ok_s)) begin
         // Storage is (or becomes) empty, so the incoming word is the new head.
         head_next_s = push_data;
      end else begin
         head_next_s = mem_r[rd_next_s];
      end
   end

   // Word storage.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers, occupancy and registered head.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         head_r   <= {WIDTH{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         rd_ptr_r <= rd_next_s;
         count_r  <= count_next_s;
         head_r   <= head_next_s;
      end
   end

endmodule

// File: rtl/serial_peri_receiver.sv
// Responder for the bit-banged 3-wire serial link: synchronises the pins,
// deserialises MSB-first words and buffers them behind a valid/ready interface.
module serial_peri_receiver
   import serial_peri_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s_clock,
   input  logic             s_data,
   input  logic             s_cs,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             overflow,
   input  logic             clear_ovf,
   output logic             frame_err,
   output logic             busy
);

   localparam int BIT_W  = $clog2(WIDTH);
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

   // [0] first sync stage, [1] synced value, [2] previous synced value
   logic [2:0]        sclk_r;
   logic [1:0]        sdat_r;
   logic [2:0]        scs_r;
   logic [1:0]        settle_r;
   rx_state_e         state_r, state_next_s;
   logic [BIT_W-1:0]  bit_cnt_r;
   logic [WIDTH-1:0]  shift_r;
   logic [WIDTH-1:0]  word_r;
   logic              push_r;
   logic              frame_err_r, busy_r, overflow_r;

   logic              sclk_rise_s, cs_rise_s, cs_fall_s;
   logic              start_s, shift_en_s, abort_s, err_s;
   logic              fifo_full_s, fifo_empty_s, drop_s;
   logic [FCNT_W-1:0] fifo_count_s;

   assign sclk_rise_s = sclk_r[1] & ~sclk_r[2];
   assign cs_rise_s   = scs_r[1] & ~scs_r[2];
   assign cs_fall_s   = ~scs_r[1] & scs_r[2];

   // Pin synchronisers and edge-detect history.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sclk_r <= 3'b000;
         sdat_r <= 2'b00;
         scs_r  <= 3'b111;
      end else begin
         sclk_r <= {sclk_r[1:0], s_clock};
         sdat_r <= {sdat_r[0], s_data};
         scs_r  <= {scs_r[1:0], s_cs};
      end
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_WAIT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state and datapath strobes; WAIT only trusts s_cs once the
   // synchroniser holds real pin samples rather than reset values.
   always_comb begin
      state_next_s = state_r;
      start_s      = 1'b0;
      shift_en_s   = 1'b0;
      abort_s      = 1'b0;
      err_s        = 1'b0;
      case (state_r)
         ST_WAIT: begin
            if ((settle_r == 2'd3) && scs_r[1]) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_IDLE: begin
            if (cs_fall_s) begin
               state_next_s = ST_RECV;
               start_s      = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (cs_rise_s) begin
               state_next_s = ST_IDLE;
               abort_s      = 1'b1;
               err_s        = (bit_cnt_r != {BIT_W{1'b0}});
            end else if (sclk_rise_s) begin
               state_next_s = ST_RECV;
               shift_en_s   = 1'b1;
            end else begin
               state_next_s = ST_RECV;
            end
         end
         default: begin
            state_next_s = ST_WAIT;
         end
      endcase
   end

   // Shifter, bit counter and completed-word hand-off to the FIFO.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bit_cnt_r <= {BIT_W{1'b0}};
         shift_r   <= {WIDTH{1'b0}};
         word_r    <= {WIDTH{1'b0}};
         push_r    <= 1'b0;
      end else begin
         push_r <= 1'b0;
         if (start_s || abort_s) begin
            bit_cnt_r <= {BIT_W{1'b0}};
            shift_r   <= {WIDTH{1'b0}};
         end else if (shift_en_s) begin
            shift_r <= {shift_r[WIDTH-2:0], sdat_r[1]};
            if (bit_cnt_r == BIT_W'(WIDTH - 1)) begin
               bit_cnt_r <= {BIT_W{1'b0}};
               word_r    <= {shift_r[WIDTH-2:0], sdat_r[1]};
               push_r    <= 1'b1;
            end else begin
               bit_cnt_r <= bit_cnt_r + BIT_W'(1'b1);
            end
         end
      end
   end

   // Status outputs and the post-reset settle counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         settle_r    <= 2'd0;
         frame_err_r <= 1'b0;
         busy_r      <= 1'b0;
         overflow_r  <= 1'b0;
      end else begin
         if ((state_r == ST_WAIT) && (settle_r != 2'd3)) begin
            settle_r <= settle_r + 2'd1;
         end
         frame_err_r <= err_s;
         busy_r      <= (state_next_s == ST_RECV);
         if (drop_s) begin
            overflow_r <= 1'b1;
         end else if (clear_ovf) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign drop_s    = push_r & fifo_full_s &
                      ~(rx_ready & (fifo_count_s != {FCNT_W{1'b0}}));
   assign rx_valid  = ~fifo_empty_s;
   assign overflow  = overflow_r;
   assign frame_err = frame_err_r;
   assign busy      = busy_r;

   serial_sync_fifo #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_r),
      .push_data (word_r),
      .pop       (rx_ready),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s),
      .head      (rx_data)
   );

endmodule
